// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor. Operands are captured on the accepting edge,
// then the carry chain is broken into STAGES registered CHUNK-wide slices.
// A single global enable stalls the whole pipeline when the output is held.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    // Level 0 is the operand capture register; level k+1 holds the beat after
    // slice k has been added. Operands are only needed up to the last stage.
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] bx_q, bx_d;
    logic [STAGES:0][WIDTH-1:0]   s_q, s_d;
    logic [STAGES:0]              c_q, c_d;
    logic [STAGES:0]              v_q, v_d;
    logic                         ovf_q, ovf_d;
    logic                         en;
    logic [CHUNK:0]               slice_sum;

    // Operand slices below the current stage are already consumed and are
    // carried along only to keep the per-level words uniform.
    logic                         unused_consumed;
    assign unused_consumed = ^{a_q, bx_q};

    assign en        = !v_q[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES];
    assign sum       = s_q[STAGES];
    assign carry_out = c_q[STAGES];
    assign overflow  = ovf_q;

    // Next-state for every pipeline level: capture, per-slice add, shift.
    always_comb begin
        a_d       = '0;
        bx_d      = '0;
        s_d       = '0;
        c_d       = '0;
        v_d       = '0;
        slice_sum = '0;

        a_d[0]  = a;
        bx_d[0] = sub ? ~b : b;
        c_d[0]  = carry_in;
        v_d[0]  = in_valid;

        for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            bx_d[k] = bx_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_sum = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                      + {1'b0, bx_q[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, c_q[k]};
            s_d[k+1]                  = s_q[k];
            s_d[k+1][k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
            c_d[k+1]                  = slice_sum[CHUNK];
            v_d[k+1]                  = v_q[k];
        end

        // Same-sign operands producing an opposite-sign result.
        ovf_d = (a_q[STAGES-1][WIDTH-1] == bx_q[STAGES-1][WIDTH-1]) &&
                (s_d[STAGES][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    end

    // Pipeline registers: cleared on reset, all levels advance together on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            bx_q  <= '0;
            s_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            a_q   <= a_d;
            bx_q  <= bx_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined adder/subtractor that generalises the 4-bit ripple-carry adder. It accepts any width and splits the carry chain into a configurable number of registered stages. It adds a subtract mode, a signed-overflow flag, and valid/ready flow control. It sits in the datapath wherever a wide add or subtract must close timing at full clock rate with one result per cycle.

## Interface
- WIDTH, 16, operand/result width in bits.
  - Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages.
  - Each stage adds one CHUNK = WIDTH/STAGES slice.
  - STAGES=1 is legal: a single registered full-width add.
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- sub  input  1  0: a+b+carry_in; 1: a+~b+carry_in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow.

## Operation
- An input beat is accepted when in_valid && in_ready.
- a, b, carry_in and sub are sampled together on the accepting edge.
- Effective operand: bx = sub ? ~b : b.
  - Subtraction a-b requires carry_in=1.
  - Borrow-in is expressed as carry_in=0.
- Stage k (k = 0..STAGES-1) adds a[k*CHUNK +: CHUNK] + bx[same slice] + c_k.
  - c_0 = carry_in.
  - c_{k+1} is the registered carry out of stage k.
- Unprocessed upper operand slices travel forward with the beat, registered each stage.
- Completed lower sum slices are registered forward each stage, so every beat's slices stay aligned.
- Each stage holds a valid bit. A beat's valid bit shifts with its data.
- carry_out is the carry out of the top slice.
- overflow = (carry into bit WIDTH-1) XOR carry_out.
  - Equivalently, a[W-1] == bx[W-1] and sum[W-1] != a[W-1].
- Flow control uses a global enable: en = !out_valid || out_ready.
  - in_ready = en.
  - When en=0, every stage (data and valid bits) holds.
  - Bubbles inside the pipeline are not collapsed.
- A beat accepted with in_valid=0 shifts a bubble in: the valid bit is 0 and the data is don't-care.
- sum, carry_out and overflow are held stable while out_valid=1 && out_ready=0.
- Arithmetic is modulo 2^WIDTH. No saturation.
- sub, carry_in, a and b are arbitrary every cycle. Per-beat mode switching is required.

## Timing
- Latency is STAGES cycles from acceptance to out_valid, provided no stall occurs in between.
  - Example: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES.
  - Each stalled cycle adds one cycle of latency.
- Throughput is one beat per cycle when out_ready=1 continuously.
- Simultaneous events:
  - When out_valid=1 and out_ready=1, a new beat is accepted in the same cycle and the pipeline shifts.
  - When out_valid=0, in_ready=1 regardless of out_ready.
- Reset (rst=1 at a rising edge):
  - All stage valid bits clear.
  - out_valid=0; sum, carry_out and overflow are 0.
  - in_ready is 1 in the cycle after reset.
  - Beats in flight are discarded, with no partial output.
  - in_valid during a reset cycle is ignored.
- Between reset and the first output, out_valid stays 0 for at least STAGES cycles after the first accept.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0.
  - Exactly 4 cycles later: sum=0x0000, carry_out=1, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0.
  - Result: sum=0x8000, carry_out=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, cin=1, sub=1.
  - Result: sum=0xFFFE, carry_out=0, overflow=0.
  - Follow with a=0x8000, b=0x0001, cin=1, sub=1: sum=0x7FFF, carry_out=1, overflow=1.
- Streaming: 64 back-to-back random beats (random sub/cin), out_ready=1.
  - One result per cycle, in order, each matching the model a+(sub?~b:b)+cin.
- Backpressure: random out_ready (~50%) with random in_valid gaps.
  - No beat is lost or duplicated.
  - sum, carry_out and overflow are stable while out_valid && !out_ready.
  - in_ready == (!out_valid || out_ready) every cycle.
- Reset mid-operation: accept 3 beats, then assert rst for 1 cycle.
  - out_valid stays 0 for all of them.
  - A beat accepted immediately after reset emerges 4 cycles later and is correct.
